// File: rtl/reorder_buffer_pkg.sv
// Shared ROB sizing and dispatch-entry field widths.
// Imported by the ROB, reservation station, load/store buffer and decoder.
package reorder_buffer_pkg;

    localparam int ROB_WIDTH = 3;
    localparam int ROB_SIZE  = 2 ** ROB_WIDTH;
    localparam int REG_W     = 5;
    localparam int XLEN      = 32;

    typedef logic [ROB_WIDTH-1:0] rob_id_t;
    typedef logic [ROB_WIDTH:0]   rob_cnt_t;
    typedef logic [REG_W-1:0]     reg_id_t;
    typedef logic [XLEN-1:0]      word_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch, operand query, writeback, retire and flush signals of the ROB.
// slave is the ROB side, master is the surrounding core side.
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic    dec_en;
    logic    dec_rdy;
    logic    dec_has_dest;
    reg_id_t dec_rd;
    logic    dec_is_branch;
    logic    dec_pred_taken;
    word_t   dec_alt_pc;
    rob_id_t dec_rob_id;

    rob_id_t q_j_id;
    rob_id_t q_k_id;
    logic    q_j_ready;
    logic    q_k_ready;
    word_t   q_j_data;
    word_t   q_k_data;

    logic    rs_en;
    logic    rs_rdy;
    rob_id_t rs_rob_id;
    word_t   rs_data;

    logic    lsb_en;
    logic    lsb_rdy;
    rob_id_t lsb_rob_id;
    word_t   lsb_data;

    logic    rf_en;
    reg_id_t rf_rd;
    word_t   rf_data;
    rob_id_t rf_rob_id;

    logic    flush;
    word_t   flush_pc;

    modport slave (
        output dec_en, dec_rob_id,
        input  dec_rdy, dec_has_dest, dec_rd,
        input  dec_is_branch, dec_pred_taken, dec_alt_pc,
        input  q_j_id, q_k_id,
        output q_j_ready, q_k_ready, q_j_data, q_k_data,
        output rs_en, lsb_en,
        input  rs_rdy, rs_rob_id, rs_data,
        input  lsb_rdy, lsb_rob_id, lsb_data,
        output rf_en, rf_rd, rf_data, rf_rob_id,
        output flush, flush_pc
    );

    modport master (
        input  dec_en, dec_rob_id,
        output dec_rdy, dec_has_dest, dec_rd,
        output dec_is_branch, dec_pred_taken, dec_alt_pc,
        output q_j_id, q_k_id,
        input  q_j_ready, q_k_ready, q_j_data, q_k_data,
        input  rs_en, lsb_en,
        output rs_rdy, rs_rob_id, rs_data,
        output lsb_rdy, lsb_rob_id, lsb_data,
        input  rf_en, rf_rd, rf_data, rf_rob_id,
        input  flush, flush_pc
    );

endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates ids, captures writebacks,
// retires in program order and flushes on a mispredicted head branch.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic clk_in,
    input  logic rst_in,
    input  logic rdy_in,
    reorder_buffer_if.slave bus
);

    localparam rob_cnt_t FULL = rob_cnt_t'(ROB_SIZE);

    logic    busy       [ROB_SIZE];
    logic    ready      [ROB_SIZE];
    logic    has_dest   [ROB_SIZE];
    logic    is_branch  [ROB_SIZE];
    logic    pred_taken [ROB_SIZE];
    reg_id_t rd         [ROB_SIZE];
    word_t   alt_pc     [ROB_SIZE];
    word_t   data       [ROB_SIZE];

    rob_id_t  head;
    rob_id_t  tail;
    rob_cnt_t count;
    logic     flush_q;
    word_t    flush_pc_q;

    logic dec_xfer;
    logic rs_xfer;
    logic lsb_xfer;
    logic commit;
    logic mispredict;
    logic rf_write;

    assign bus.dec_en     = (count < FULL) && !flush_q;
    assign bus.rs_en      = !flush_q;
    assign bus.lsb_en     = !flush_q;
    assign bus.dec_rob_id = tail;
    assign bus.flush      = flush_q;
    assign bus.flush_pc   = flush_pc_q;

    assign dec_xfer = bus.dec_en && bus.dec_rdy && rdy_in;
    assign rs_xfer  = bus.rs_en && bus.rs_rdy && rdy_in;
    assign lsb_xfer = bus.lsb_en && bus.lsb_rdy && rdy_in;

    // Commit reads registered ready only; no writeback-to-retire bypass.
    assign commit = rdy_in && !flush_q && busy[head] && ready[head];
    assign mispredict = commit && is_branch[head]
                        && (data[head][0] != pred_taken[head]);
    assign rf_write = commit && has_dest[head] && !is_branch[head];

    assign bus.rf_en     = rf_write;
    assign bus.rf_rd     = rf_write ? rd[head]   : '0;
    assign bus.rf_data   = rf_write ? data[head] : '0;
    assign bus.rf_rob_id = rf_write ? head       : '0;

    // Operand lookup with same-cycle writeback bypass, RS over LSB.
    always_comb begin
        bus.q_j_ready = ready[bus.q_j_id];
        bus.q_j_data  = data[bus.q_j_id];
        if (lsb_xfer && bus.lsb_rob_id == bus.q_j_id) begin
            bus.q_j_ready = 1'b1;
            bus.q_j_data  = bus.lsb_data;
        end
        if (rs_xfer && bus.rs_rob_id == bus.q_j_id) begin
            bus.q_j_ready = 1'b1;
            bus.q_j_data  = bus.rs_data;
        end
    end

    always_comb begin
        bus.q_k_ready = ready[bus.q_k_id];
        bus.q_k_data  = data[bus.q_k_id];
        if (lsb_xfer && bus.lsb_rob_id == bus.q_k_id) begin
            bus.q_k_ready = 1'b1;
            bus.q_k_data  = bus.lsb_data;
        end
        if (rs_xfer && bus.rs_rob_id == bus.q_k_id) begin
            bus.q_k_ready = 1'b1;
            bus.q_k_data  = bus.rs_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                busy[i]  <= 1'b0;
                ready[i] <= 1'b0;
            end
        end else if (rdy_in) begin
            flush_q <= mispredict;
            if (mispredict) begin
                flush_pc_q <= alt_pc[head];
                head       <= '0;
                tail       <= '0;
                count      <= '0;
                for (int i = 0; i < ROB_SIZE; i++) begin
                    busy[i]  <= 1'b0;
                    ready[i] <= 1'b0;
                end
            end else begin
                if (lsb_xfer && busy[bus.lsb_rob_id]) begin
                    ready[bus.lsb_rob_id] <= 1'b1;
                    data[bus.lsb_rob_id]  <= bus.lsb_data;
                end
                if (rs_xfer && busy[bus.rs_rob_id]) begin
                    ready[bus.rs_rob_id] <= 1'b1;
                    data[bus.rs_rob_id]  <= bus.rs_data;
                end
                if (commit) begin
                    busy[head]  <= 1'b0;
                    ready[head] <= 1'b0;
                    head        <= head + 1'b1;
                end
                if (dec_xfer) begin
                    busy[tail]       <= 1'b1;
                    ready[tail]      <= 1'b0;
                    has_dest[tail]   <= bus.dec_has_dest;
                    rd[tail]         <= bus.dec_rd;
                    is_branch[tail]  <= bus.dec_is_branch;
                    pred_taken[tail] <= bus.dec_pred_taken;
                    alt_pc[tail]     <= bus.dec_alt_pc;
                    tail             <= tail + 1'b1;
                end
                count <= count + rob_cnt_t'(dec_xfer)
                               - rob_cnt_t'(commit);
            end
        end
    end

endmodule
